// File: rtl/exc_ctrl_if.sv
// Exception controller bus: MEM-stage instruction info and CP0 state in,
// resolved exception and pipeline control out.
interface exc_ctrl_if;
    logic [5:0]  ext_int_i;
    logic        mem_valid_i;
    logic        mem_stall_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delay_i;
    logic [31:0] mem_addr_i;
    logic        if_adel_i;
    logic        ri_i;
    logic        ov_i;
    logic        sys_i;
    logic        bp_i;
    logic        eret_i;
    logic        dadel_i;
    logic        dades_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [5:0]  int_o;
    logic [4:0]  exccode_o;
    logic [31:0] pc_o;
    logic        in_delay_o;
    logic [31:0] badvaddr_o;
    logic        flush_hold_o;
    logic        mem_kill_o;

    // Pipeline / CP0 side: supplies instruction state, consumes exception results.
    modport master (
        output ext_int_i, mem_valid_i, mem_stall_i, mem_pc_i, mem_in_delay_i, mem_addr_i,
               if_adel_i, ri_i, ov_i, sys_i, bp_i, eret_i, dadel_i, dades_i, status_i, cause_i,
        input  int_o, exccode_o, pc_o, in_delay_o, badvaddr_o, flush_hold_o, mem_kill_o
    );

    // Exception controller side.
    modport slave (
        input  ext_int_i, mem_valid_i, mem_stall_i, mem_pc_i, mem_in_delay_i, mem_addr_i,
               if_adel_i, ri_i, ov_i, sys_i, bp_i, eret_i, dadel_i, dades_i, status_i, cause_i,
        output int_o, exccode_o, pc_o, in_delay_o, badvaddr_o, flush_hold_o, mem_kill_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: resolves exception priority for the committing
// instruction, presents one code to CP0, then holds a flush window while the
// pipeline drains. Also synchronizes the hardware interrupt lines.
module exc_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [4:0]  EXC_NONE     = 5'h10,
    parameter logic [4:0]  EXC_ERET     = 5'h0e
) (
    input logic     cpu_clk_50M,
    input logic     cpu_rst,
    exc_ctrl_if.slave bus
);

    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  int_meta_q, int_sync_q;
    logic        int_pend;
    logic        commit;
    logic [4:0]  exc_code;
    logic [31:0] exc_bad;

    logic unused_bits;
    assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                           bus.cause_i[31:10], bus.cause_i[7:0]};

    // Two-flop synchronizer per interrupt line, no filtering.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            int_meta_q <= 6'd0;
            int_sync_q <= 6'd0;
        end else begin
            int_meta_q <= bus.ext_int_i;
            int_sync_q <= int_meta_q;
        end
    end

    assign bus.int_o = int_sync_q;

    // Interrupt is pending only when masked-in, globally enabled and not already in EXL.
    assign int_pend = (|(bus.status_i[15:8] & {int_sync_q, bus.cause_i[9:8]}))
                      & bus.status_i[0] & ~bus.status_i[1];

    // Fixed-priority exception resolution and bad-address selection.
    always_comb begin
        exc_code = EXC_NONE;
        exc_bad  = 32'd0;
        if (int_pend) begin
            exc_code = 5'h00;
        end else if (bus.if_adel_i) begin
            exc_code = 5'h04;
            exc_bad  = bus.mem_pc_i;
        end else if (bus.ri_i) begin
            exc_code = 5'h0a;
        end else if (bus.ov_i) begin
            exc_code = 5'h0c;
        end else if (bus.sys_i) begin
            exc_code = 5'h08;
        end else if (bus.bp_i) begin
            exc_code = 5'h09;
        end else if (bus.eret_i) begin
            exc_code = EXC_ERET;
        end else if (bus.dadel_i) begin
            exc_code = 5'h04;
            exc_bad  = bus.mem_addr_i;
        end else if (bus.dades_i) begin
            exc_code = 5'h05;
            exc_bad  = bus.mem_addr_i;
        end
    end

    // Gating with reset keeps the presented code at NONE while reset is held.
    assign commit = bus.mem_valid_i & ~bus.mem_stall_i & ~cpu_rst;

    // State register and flush countdown.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bus.exccode_o    = EXC_NONE;
        bus.pc_o         = 32'd0;
        bus.in_delay_o   = 1'b0;
        bus.badvaddr_o   = 32'd0;
        bus.flush_hold_o = 1'b0;
        bus.mem_kill_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (commit && (exc_code != EXC_NONE)) begin
                    bus.exccode_o  = exc_code;
                    bus.pc_o       = bus.mem_pc_i;
                    bus.in_delay_o = bus.mem_in_delay_i;
                    bus.badvaddr_o = exc_bad;
                    bus.mem_kill_o = 1'b1;
                    state_d        = StFlush;
                    cnt_d          = FlushInit;
                end
            end
            StFlush: begin
                bus.flush_hold_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed testbench for exc_ctrl with a scoreboard of expected per-cycle outputs.
module tb_exc_ctrl;

    localparam logic [4:0] NONE = 5'h10;
    localparam logic [4:0] ERET = 5'h0e;

    typedef struct packed {
        logic [5:0]  iv;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        dly;
        logic [31:0] bad;
        logic        hold;
        logic        kill;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t  sb[$];
    string tq[$];

    exc_ctrl_if bus();

    exc_ctrl #(.FLUSH_CYCLES(2)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [5:0] iv, input logic [4:0] code,
                              input logic [31:0] pc, input logic dly, input logic [31:0] bad,
                              input logic hold, input logic kill);
        exp_t e;
        e = '{iv: iv, code: code, pc: pc, dly: dly, bad: bad, hold: hold, kill: kill};
        sb.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic compare_pop();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=0 expected>0");
        end else begin
            e = sb.pop_front();
            t = tq.pop_front();
            chk(t, "int",   {26'd0, bus.int_o},      {26'd0, e.iv});
            chk(t, "code",  {27'd0, bus.exccode_o},  {27'd0, e.code});
            chk(t, "pc",    bus.pc_o,                e.pc);
            chk(t, "dly",   {31'd0, bus.in_delay_o}, {31'd0, e.dly});
            chk(t, "bad",   bus.badvaddr_o,          e.bad);
            chk(t, "hold",  {31'd0, bus.flush_hold_o}, {31'd0, e.hold});
            chk(t, "kill",  {31'd0, bus.mem_kill_o}, {31'd0, e.kill});
        end
    endtask

    // Compare on the falling edge, then advance to just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.mem_valid_i    = 1'b0;
        bus.mem_stall_i    = 1'b0;
        bus.mem_pc_i       = 32'd0;
        bus.mem_in_delay_i = 1'b0;
        bus.mem_addr_i     = 32'd0;
        bus.if_adel_i      = 1'b0;
        bus.ri_i           = 1'b0;
        bus.ov_i           = 1'b0;
        bus.sys_i          = 1'b0;
        bus.bp_i           = 1'b0;
        bus.eret_i         = 1'b0;
        bus.dadel_i        = 1'b0;
        bus.dades_i        = 1'b0;
    endtask

    task automatic flush2(input string tag, input logic [5:0] iv);
        expect_out(tag, iv, NONE, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle();
        expect_out(tag, iv, NONE, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        cycle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        bus.ext_int_i = 6'd0;
        bus.status_i  = 32'd0;
        bus.cause_i   = 32'd0;

        // Reset state
        expect_out("reset", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        expect_out("reset", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        rst = 1'b0;
        expect_out("idle", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();

        // Overflow: one-cycle code, then flush with inputs still asserted (ignored)
        bus.mem_valid_i = 1'b1;
        bus.ov_i        = 1'b1;
        bus.mem_pc_i    = 32'hBFC00100;
        expect_out("ov", 6'd0, 5'h0c, 32'hBFC00100, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        flush2("ov_flush", 6'd0);
        clear_inputs();
        expect_out("ov_idle", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();

        // Fetch address error beats overflow and data address error
        bus.mem_valid_i = 1'b1;
        bus.if_adel_i   = 1'b1;
        bus.ov_i        = 1'b1;
        bus.dadel_i     = 1'b1;
        bus.mem_pc_i    = 32'h00000003;
        bus.mem_addr_i  = 32'h00001234;
        expect_out("prio", 6'd0, 5'h04, 32'h00000003, 1'b0, 32'h00000003, 1'b0, 1'b1);
        cycle();
        clear_inputs();
        flush2("prio_flush", 6'd0);

        // Store address error held off by stall
        bus.mem_valid_i = 1'b1;
        bus.mem_stall_i = 1'b1;
        bus.dades_i     = 1'b1;
        bus.mem_pc_i    = 32'h00000100;
        bus.mem_addr_i  = 32'h80000002;
        for (int i = 0; i < 3; i++) begin
            expect_out("stall", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
            cycle();
        end
        bus.mem_stall_i = 1'b0;
        expect_out("dades", 6'd0, 5'h05, 32'h00000100, 1'b0, 32'h80000002, 1'b0, 1'b1);
        cycle();
        clear_inputs();
        flush2("dades_flush", 6'd0);

        // Interrupt: two-edge sync latency, no take without a valid instruction
        bus.status_i  = 32'h00000401;
        bus.ext_int_i = 6'b000001;
        expect_out("int_sync0", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        expect_out("int_sync1", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        expect_out("int_novalid", 6'd1, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i    = 32'h00000200;
        expect_out("int_take", 6'd1, 5'h00, 32'h00000200, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        clear_inputs();
        flush2("int_flush", 6'd1);
        bus.status_i    = 32'h00000403;
        bus.mem_valid_i = 1'b1;
        bus.mem_pc_i    = 32'h00000204;
        expect_out("int_exl", 6'd1, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        clear_inputs();
        bus.status_i  = 32'd0;
        bus.ext_int_i = 6'd0;
        expect_out("int_drop0", 6'd1, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        expect_out("int_drop1", 6'd1, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        expect_out("int_drop2", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();

        // Eret in a delay slot
        bus.mem_valid_i    = 1'b1;
        bus.eret_i         = 1'b1;
        bus.mem_in_delay_i = 1'b1;
        bus.mem_pc_i       = 32'h00001004;
        expect_out("eret", 6'd0, ERET, 32'h00001004, 1'b1, 32'd0, 1'b0, 1'b1);
        cycle();
        clear_inputs();
        flush2("eret_flush", 6'd0);

        // Async reset mid-flush
        bus.ext_int_i = 6'h3f;
        expect_out("rst_pre0", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        expect_out("rst_pre1", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();
        bus.mem_valid_i = 1'b1;
        bus.sys_i       = 1'b1;
        bus.mem_pc_i    = 32'h00000300;
        expect_out("sys1", 6'h3f, 5'h08, 32'h00000300, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        clear_inputs();
        bus.ext_int_i = 6'd0;
        expect_out("mid_flush", 6'h3f, NONE, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        compare_pop();
        #1;
        rst = 1'b1;
        #1;
        expect_out("rst_async", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        compare_pop();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.sys_i       = 1'b1;
        bus.mem_pc_i    = 32'h00000400;
        expect_out("sys2", 6'd0, 5'h08, 32'h00000400, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle();
        clear_inputs();
        flush2("sys2_flush", 6'd0);
        expect_out("final_idle", 6'd0, NONE, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        cycle();

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
